// File: rtl/startup_display_driver.sv
// Responder side of the startup display handshake: pattern address counter,
// sequencer timer and the serial loader for the front-panel LED register.
module startup_display_driver #(
    parameter int NPAT   = 16,
    parameter int AW     = 4,
    parameter int DW     = 8,
    parameter int CLKDIV = 4
) (
    input  logic          CLK,
    input  logic          RST_B,
    input  logic          CLEAR,
    input  logic          DISP,
    input  logic          LOAD_PAT,
    input  logic          NXT_ADR,
    input  logic          RST_TMR,
    input  logic [DW-1:0] ROM_DATA,
    output logic [AW-1:0] ROM_ADR,
    output logic [15:0]   TMR,
    output logic          DONE,
    output logic          BUSY,
    output logic          SCLK,
    output logic          SDOUT,
    output logic          LATCH,
    output logic          OE_B
);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

    localparam int            CW       = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int            BW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0] DIV_LD   = CW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LD   = BW'(DW - 1);
    localparam logic [AW-1:0] ADR_LAST = AW'(NPAT - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [15:0]   tmr_q, tmr_d;
    logic          done_q, done_d;
    logic          oe_b_q, oe_b_d;
    logic [DW-1:0] shreg_q, shreg_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [CW-1:0] div_q, div_d;
    logic          sclk_q, sclk_d;
    logic          latch_q, latch_d;
    logic          busy_q, busy_d;

    always_comb begin
        adr_d = adr_q;
        if (CLEAR)
            adr_d = '0;
        else if (NXT_ADR && (adr_q != ADR_LAST))
            adr_d = adr_q + 1'b1;

        tmr_d = tmr_q;
        if (RST_TMR)
            tmr_d = '0;
        else if (tmr_q != 16'hFFFF)
            tmr_d = tmr_q + 16'd1;

        done_d = (adr_q == ADR_LAST);
        oe_b_d = ~(DISP & ~CLEAR);

        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        latch_d = latch_q;
        busy_d  = busy_q;

        if (CLEAR) begin
            state_d = S_IDLE;
            shreg_d = '0;
            bit_d   = '0;
            div_d   = '0;
            sclk_d  = 1'b0;
            latch_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (LOAD_PAT) begin
                        state_d = S_SHIFT;
                        shreg_d = ROM_DATA;
                        bit_d   = BIT_LD;
                        div_d   = DIV_LD;
                        sclk_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (div_q != '0) begin
                        div_d = div_q - 1'b1;
                    end else if (!sclk_q) begin
                        sclk_d = 1'b1;
                        div_d  = DIV_LD;
                    end else if (bit_q == '0) begin
                        state_d = S_LATCH;
                        sclk_d  = 1'b0;
                        latch_d = 1'b1;
                        div_d   = DIV_LD;
                    end else begin
                        // SDOUT is the shreg MSB, so shifting presents the next bit
                        sclk_d  = 1'b0;
                        shreg_d = {shreg_q[DW-2:0], 1'b0};
                        bit_d   = bit_q - 1'b1;
                        div_d   = DIV_LD;
                    end
                end
                S_LATCH: begin
                    if (div_q != '0) begin
                        div_d = div_q - 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        latch_d = 1'b0;
                        busy_d  = 1'b0;
                        shreg_d = '0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_B) begin
            state_q <= S_IDLE;
            adr_q   <= '0;
            tmr_q   <= '0;
            done_q  <= 1'b0;
            oe_b_q  <= 1'b1;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            tmr_q   <= tmr_d;
            done_q  <= done_d;
            oe_b_q  <= oe_b_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
        end
    end

    assign ROM_ADR = adr_q;
    assign TMR     = tmr_q;
    assign DONE    = done_q;
    assign BUSY    = busy_q;
    assign SCLK    = sclk_q;
    assign SDOUT   = shreg_q[DW-1];
    assign LATCH   = latch_q;
    assign OE_B    = oe_b_q;

endmodule

// File: tb/tb_startup_display_driver.sv
// Bench for startup_display_driver: timer, address counter and LED serial
// loader compared against a cycle-offset model of the panel waveform.
module tb_startup_display_driver;

    logic       CLK = 1'b0;
    logic       RST_B, CLEAR, DISP, LOAD_PAT, NXT_ADR, RST_TMR;
    logic [7:0] ROM_DATA;
    logic [3:0] ROM_ADR;
    logic [15:0] TMR;
    logic       DONE, BUSY, SCLK, SDOUT, LATCH, OE_B;

    int checks = 0;
    int errors = 0;

    startup_display_driver dut (
        .CLK(CLK), .RST_B(RST_B), .CLEAR(CLEAR), .DISP(DISP),
        .LOAD_PAT(LOAD_PAT), .NXT_ADR(NXT_ADR), .RST_TMR(RST_TMR),
        .ROM_DATA(ROM_DATA), .ROM_ADR(ROM_ADR), .TMR(TMR), .DONE(DONE),
        .BUSY(BUSY), .SCLK(SCLK), .SDOUT(SDOUT), .LATCH(LATCH), .OE_B(OE_B)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Expected panel outputs k cycles after the capture edge (k=0 is the
    // cycle right after capture): 8 bits of 8 cycles each (4 low, 4 high),
    // then a 4-cycle latch, then idle.
    function automatic logic [3:0] model_wave(input logic [7:0] pat, input int k);
        logic b, s, l, d;
        b = (k < 68);
        s = (k < 64) && ((k % 8) >= 4);
        l = (k >= 64) && (k < 68);
        d = (k < 64) ? pat[7 - k / 8] : 1'b0;
        return {b, s, l, d};
    endfunction

    task automatic test_reset();
        RST_B = 1'b0;
        for (int i = 0; i < 3; i++) begin
            CLEAR    = 1'($urandom);
            DISP     = 1'($urandom);
            LOAD_PAT = 1'($urandom);
            NXT_ADR  = 1'($urandom);
            RST_TMR  = 1'($urandom);
            ROM_DATA = 8'($urandom);
            tick();
            checks++;
            if ({ROM_ADR, TMR, DONE, BUSY, SCLK, SDOUT, LATCH, OE_B} !==
                {4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL reset_state cycle %0d: adr=%0d tmr=%0d done=%b busy=%b sclk=%b sdout=%b latch=%b oe_b=%b, expected all 0 with oe_b=1",
                         i, ROM_ADR, TMR, DONE, BUSY, SCLK, SDOUT, LATCH, OE_B);
            end
        end
        RST_B = 1'b1; DISP = 1'b1; CLEAR = 1'b0; LOAD_PAT = 1'b0;
        NXT_ADR = 1'b0; RST_TMR = 1'b0;
        tick();
        checks++;
        if (OE_B !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_oe_b: got %b expected 0", OE_B);
        end
    endtask

    task automatic test_timer();
        logic [15:0] exp;
        RST_TMR = 1'b1;
        tick();
        checks++;
        if (TMR !== 16'd0) begin
            errors++;
            $display("FAIL timer_hold: got %0d expected 0", TMR);
        end
        RST_TMR = 1'b0;
        for (int k = 1; k <= 70000; k++) begin
            tick();
            exp = (k > 65535) ? 16'hFFFF : k[15:0];
            if (k == 1 || k == 3000 || k == 65534 || k == 65535 || k == 65536 || k == 70000) begin
                checks++;
                if (TMR !== exp) begin
                    errors++;
                    $display("FAIL timer_count k=%0d: got %h expected %h", k, TMR, exp);
                end
            end
        end
        RST_TMR = 1'b1;
        tick();
        checks++;
        if (TMR !== 16'd0) begin
            errors++;
            $display("FAIL timer_clear: got %h expected 0", TMR);
        end
        RST_TMR = 1'b0;
    endtask

    task automatic test_address();
        int exp, prev;
        CLEAR = 1'b1; tick(); CLEAR = 1'b0; tick();
        checks++;
        if (ROM_ADR !== 4'd0 || DONE !== 1'b0) begin
            errors++;
            $display("FAIL adr_clear_start: adr=%0d done=%b expected 0/0", ROM_ADR, DONE);
        end
        exp = 0;
        for (int p = 1; p <= 16; p++) begin
            NXT_ADR = 1'b1; tick(); NXT_ADR = 1'b0;
            prev = exp;
            exp = (exp < 15) ? exp + 1 : 15;
            checks++;
            if (ROM_ADR !== 4'(exp) || DONE !== 1'(prev == 15)) begin
                errors++;
                $display("FAIL adr_step pulse %0d: adr=%0d done=%b expected %0d/%b",
                         p, ROM_ADR, DONE, exp, prev == 15);
            end
            tick();
            checks++;
            if (DONE !== 1'(exp == 15)) begin
                errors++;
                $display("FAIL adr_done pulse %0d: got %b expected %b", p, DONE, exp == 15);
            end
            tick();
        end
        CLEAR = 1'b1; NXT_ADR = 1'b1; tick(); CLEAR = 1'b0; NXT_ADR = 1'b0;
        checks++;
        if (ROM_ADR !== 4'd0) begin
            errors++;
            $display("FAIL adr_clear_prio: got %0d expected 0", ROM_ADR);
        end
        tick();
        checks++;
        if (DONE !== 1'b0) begin
            errors++;
            $display("FAIL adr_clear_done: got %b expected 0", DONE);
        end
    endtask

    task automatic run_shift(input logic [7:0] pat, input int inject);
        logic [3:0] exp;
        ROM_DATA = pat; LOAD_PAT = 1'b1;
        tick();
        LOAD_PAT = 1'b0;
        for (int k = 0; k < 72; k++) begin
            exp = model_wave(pat, k);
            checks++;
            // SDOUT is left unconstrained while LATCH is high
            if (BUSY !== exp[3] || SCLK !== exp[2] || LATCH !== exp[1] ||
                ((k < 64 || k >= 68) && SDOUT !== exp[0])) begin
                errors++;
                $display("FAIL shift_wave pat=%h k=%0d: busy/sclk/latch/sdout=%b%b%b%b expected %b",
                         pat, k, BUSY, SCLK, LATCH, SDOUT, exp);
            end
            if (k == inject) begin
                LOAD_PAT = 1'b1; ROM_DATA = 8'hFF;
            end else begin
                LOAD_PAT = 1'b0;
            end
            tick();
        end
        LOAD_PAT = 1'b0;
    endtask

    task automatic test_shift();
        run_shift(8'hA5, -1);
        for (int i = 0; i < 4; i++) run_shift(8'($urandom), -1);
    endtask

    task automatic test_load_ignored();
        run_shift(8'hA5, 20);
        run_shift(8'($urandom), 5);
    endtask

    task automatic start_and_run_to_30();
        repeat (3) begin NXT_ADR = 1'b1; tick(); NXT_ADR = 1'b0; tick(); end
        ROM_DATA = 8'($urandom) | 8'h01; LOAD_PAT = 1'b1;
        tick();
        LOAD_PAT = 1'b0;
        repeat (30) tick();
    endtask

    task automatic watch_no_latch(input string name);
        int seen;
        seen = 0;
        for (int k = 0; k < 80; k++) begin
            tick();
            if (LATCH !== 1'b0 || BUSY !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL %s: latch/busy active in %0d cycles, expected 0", name, seen);
        end
    endtask

    task automatic test_clear_abort();
        DISP = 1'b1;
        start_and_run_to_30();
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        checks++;
        if ({BUSY, SCLK, LATCH, SDOUT, OE_B, ROM_ADR} !== {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL clear_abort: busy=%b sclk=%b latch=%b sdout=%b oe_b=%b adr=%0d expected 0000 1 0",
                     BUSY, SCLK, LATCH, SDOUT, OE_B, ROM_ADR);
        end
        watch_no_latch("clear_no_latch");
    endtask

    task automatic test_reset_abort();
        DISP = 1'b1;
        start_and_run_to_30();
        RST_B = 1'b0;
        tick();
        RST_B = 1'b1;
        checks++;
        if ({ROM_ADR, TMR, DONE, BUSY, SCLK, SDOUT, LATCH, OE_B} !==
            {4'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_abort: adr=%0d tmr=%0d done=%b busy=%b sclk=%b sdout=%b latch=%b oe_b=%b",
                     ROM_ADR, TMR, DONE, BUSY, SCLK, SDOUT, LATCH, OE_B);
        end
        watch_no_latch("reset_no_latch");
    endtask

    initial begin
        RST_B = 1'b0; CLEAR = 1'b0; DISP = 1'b0; LOAD_PAT = 1'b0;
        NXT_ADR = 1'b0; RST_TMR = 1'b0; ROM_DATA = 8'h00;
        test_reset();
        test_timer();
        test_address();
        test_shift();
        test_load_ignored();
        test_clear_abort();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
